// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED matrix video buffer loader.
//   COLS, ROWS : matrix geometry (one byte of vbuf per column)
//   VBUF_W     : width of the display buffer / serial frame
//   BITCNT_W   : bit counter width, wide enough to hold VBUF_W itself
//   state_e    : loader FSM states
package led_pkg;

    localparam int COLS     = 8;
    localparam int ROWS     = 8;
    localparam int VBUF_W   = COLS * ROWS;
    localparam int BITCNT_W = $clog2(VBUF_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PEND  = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: N-stage synchronizer for an asynchronous input, followed by one
// edge-detect flop.
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input pin
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized rising / falling edges
// A pin change shows on level after N clocks and is acted on one clock later
// through the edge pulses.
module sync_edge #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_r;
    logic         prev_r;

    // Synchronizer chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {N{RST_VAL}};
            prev_r <= RST_VAL;
        end else begin
            sync_r <= (sync_r << 1) | {{(N-1){1'b0}}, din};
            prev_r <= sync_r[N-1];
        end
    end

    assign level = sync_r[N-1];
    assign rise  = sync_r[N-1] & ~prev_r;
    assign fall  = ~sync_r[N-1] & prev_r;

endmodule

// File: rtl/vbuf_loader.sv
// vbuf_loader: serial write port for the LED matrix video buffer.
//   clk, rst_n  : system clock, async active-low reset
//   s_cs_n      : frame select (active low, asynchronous)
//   s_clk       : serial clock, data sampled on its rising edge (asynchronous)
//   s_data      : serial data, MSB first
//   col_wrap    : pulse from the column scanner when it wraps 7 -> 0
//   vbuf        : display buffer, vbuf[8c+7:8c] is column c
//   busy        : frame being shifted or waiting for a swap
//   frame_done  : pulse on the first cycle vbuf shows a new frame
//   frame_err   : pulse when a frame is discarded
// Frames are assembled in a shadow register and copied into vbuf only on a
// column wrap, so the scanner never displays a partially written frame.
module vbuf_loader
    import led_pkg::*;
#(
    parameter int COLS        = led_pkg::COLS,
    parameter int ROWS        = led_pkg::ROWS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_cs_n,
    input  logic                 s_clk,
    input  logic                 s_data,
    input  logic                 col_wrap,
    output logic [COLS*ROWS-1:0] vbuf,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_err
);

    localparam int FRAME_W = COLS * ROWS;
    localparam int CNT_W   = $clog2(FRAME_W) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic sclk_level_s, sclk_rise_s, sclk_fall_s;
    logic data_s, data_rise_s, data_fall_s;
    logic unused_edges_s;

    state_e               state_r, state_n;
    logic [CNT_W-1:0]     cnt_r, cnt_n;
    logic                 ovf_r, ovf_n;
    logic [FRAME_W-1:0]   shadow_r, shadow_n;
    logic [FRAME_W-1:0]   vbuf_r, vbuf_n;
    logic                 done_r, done_n;
    logic                 err_r, err_n;
    logic                 busy_r;

    sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(s_cs_n),
        .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(s_clk),
        .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .din(s_data),
        .level(data_s), .rise(data_rise_s), .fall(data_fall_s)
    );

    // Only the select edges, serial clock rise and data level drive the FSM.
    assign unused_edges_s = cs_level_s | sclk_level_s | sclk_fall_s |
                            data_rise_s | data_fall_s;

    // Next-state and datapath updates for the load / pend / swap sequence.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        ovf_n    = ovf_r;
        shadow_n = shadow_r;
        vbuf_n   = vbuf_r;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_n = ST_SHIFT;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Select release takes priority over a coincident clock edge.
                if (cs_rise_s) begin
                    if ((cnt_r == CNT_FULL) && !ovf_r) begin
                        state_n = ST_PEND;
                    end else begin
                        state_n = ST_IDLE;
                        err_n   = 1'b1;
                    end
                end else if (sclk_rise_s) begin
                    if (cnt_r < CNT_FULL) begin
                        shadow_n = {shadow_r[FRAME_W-2:0], data_s};
                        cnt_n    = cnt_r + CNT_W'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                end else begin
                    state_n = ST_SHIFT;
                end
            end
            ST_PEND: begin
                // A new select window during PEND is dropped entirely: once the
                // swap returns us to IDLE its falling edge has already passed.
                err_n = cs_fall_s;
                if (col_wrap) begin
                    vbuf_n  = shadow_r;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_PEND;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, shadow, display and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            ovf_r    <= 1'b0;
            shadow_r <= '0;
            vbuf_r   <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            ovf_r    <= ovf_n;
            shadow_r <= shadow_n;
            vbuf_r   <= vbuf_n;
            done_r   <= done_n;
            err_r    <= err_n;
            busy_r   <= (state_n != ST_IDLE);
        end
    end

    assign vbuf       = vbuf_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign frame_err  = err_r;

endmodule

// File: tb/tb_vbuf_loader.sv
// Bench for vbuf_loader: directed scenarios plus randomized frames. Expected
// frame_done / frame_err events are queued when stimulus is issued; a monitor
// pops and compares whenever the DUT raises either pulse.
module tb_vbuf_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_cs_n;
    logic        s_clk;
    logic        s_data;
    logic        col_wrap;
    logic [63:0] vbuf;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    always #5 clk = ~clk;

    vbuf_loader #(.COLS(8), .ROWS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_cs_n(s_cs_n), .s_clk(s_clk),
        .s_data(s_data), .col_wrap(col_wrap), .vbuf(vbuf), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    typedef struct {
        bit          is_done;
        logic [63:0] vbuf;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          tx_q[$];
    logic [63:0] vbuf_m;
    logic [63:0] pend_v;
    bit          pend_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output event must match the oldest expected event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && (frame_done === 1'b1 || frame_err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: done=%b err=%b expected none", frame_done, frame_err);
            end else begin
                e = exp_q.pop_front();
                chk("event_is_done", {63'd0, frame_done}, {63'd0, e.is_done});
                chk("event_is_err", {63'd0, frame_err}, {63'd0, !e.is_done});
                chk(e.is_done ? "swap_vbuf" : "err_vbuf", vbuf, e.vbuf);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_word(input logic [63:0] w);
        tx_q.delete();
        for (int i = 63; i >= 0; i--) tx_q.push_back(w[i]);
    endtask

    // Reference frame value: bits in arrival order, first bit most significant.
    function automatic logic [63:0] frame_value();
        logic [63:0] v = 64'd0;
        foreach (tx_q[i]) v = {v[62:0], tx_q[i]};
        return v;
    endfunction

    // Lower select and clock out the first nbits of tx_q (select stays low).
    task automatic send_bits(input int nbits);
        s_cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            s_data = tx_q[i];
            tick(4);
            s_clk = 1'b1;
            tick(4);
            s_clk = 1'b0;
        end
    endtask

    // Raise select; a frame is accepted only if exactly 64 bits were sent.
    task automatic end_frame(input bit dropped);
        tick(4);
        s_cs_n = 1'b1;
        if (!dropped) begin
            if (tx_q.size() == 64) begin
                pend_v = frame_value();
                pend_m = 1'b1;
            end else begin
                exp_q.push_back('{1'b0, vbuf_m});
            end
        end
    endtask

    task automatic wrap();
        col_wrap = 1'b1;
        if (pend_m) begin
            vbuf_m = pend_v;
            pend_m = 1'b0;
            exp_q.push_back('{1'b1, vbuf_m});
        end
        tick(1);
        col_wrap = 1'b0;
    endtask

    initial begin
        int          n;
        logic [63:0] w;
        rst_n = 1'b0; s_cs_n = 1'b1; s_clk = 1'b0; s_data = 1'b0; col_wrap = 1'b0;
        vbuf_m = 64'd0; pend_v = 64'd0; pend_m = 1'b0;
        tick(3);
        chk("reset_vbuf", vbuf, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, frame_done}, 64'd0);
        chk("reset_err", {63'd0, frame_err}, 64'd0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // Full frame, swap 20 cycles after select release.
        load_word(64'hF0E1D2C3B4A59687);
        send_bits(64);
        end_frame(1'b0);
        tick(20);
        chk("pend_busy", {63'd0, busy}, 64'd1);
        chk("pend_vbuf_held", vbuf, 64'd0);
        wrap();
        tick(2);
        chk("post_swap_busy", {63'd0, busy}, 64'd0);
        chk("post_swap_vbuf", vbuf, 64'hF0E1D2C3B4A59687);

        // Short frame (63 bits).
        load_word({$urandom, $urandom});
        void'(tx_q.pop_back());
        send_bits(tx_q.size());
        end_frame(1'b0);
        tick(10);
        chk("short_busy", {63'd0, busy}, 64'd0);
        chk("short_vbuf", vbuf, vbuf_m);

        // Long frame (65 bits).
        load_word({$urandom, $urandom});
        tx_q.push_back(1'b1);
        send_bits(tx_q.size());
        end_frame(1'b0);
        tick(10);
        chk("long_busy", {63'd0, busy}, 64'd0);
        chk("long_vbuf", vbuf, vbuf_m);

        // Frame A pending, frame B started before the wrap is dropped.
        load_word({$urandom, $urandom});
        send_bits(64);
        end_frame(1'b0);
        tick(10);
        chk("a_pend_busy", {63'd0, busy}, 64'd1);
        exp_q.push_back('{1'b0, vbuf_m});
        load_word({$urandom, $urandom});
        send_bits(64);
        end_frame(1'b1);
        tick(10);
        chk("b_dropped_vbuf", vbuf, vbuf_m);
        chk("b_dropped_busy", {63'd0, busy}, 64'd1);
        wrap();
        tick(10);
        chk("a_swapped_busy", {63'd0, busy}, 64'd0);

        // col_wrap in the same cycle as PEND entry must not swap.
        load_word({$urandom, $urandom});
        send_bits(64);
        end_frame(1'b0);
        tick(2);
        col_wrap = 1'b1;
        tick(1);
        col_wrap = 1'b0;
        tick(5);
        chk("early_wrap_busy", {63'd0, busy}, 64'd1);
        chk("early_wrap_vbuf", vbuf, vbuf_m);
        wrap();
        tick(2);
        chk("late_wrap_vbuf", vbuf, vbuf_m);

        // Reset mid-frame after 30 bits.
        load_word({$urandom, $urandom});
        send_bits(30);
        rst_n = 1'b0;
        tick(2);
        chk("midreset_vbuf", vbuf, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        s_cs_n = 1'b1; s_clk = 1'b0;
        vbuf_m = 64'd0; pend_m = 1'b0;
        rst_n = 1'b1;
        tick(3);
        load_word({$urandom, $urandom});
        send_bits(64);
        end_frame(1'b0);
        tick(5);
        wrap();
        tick(2);
        chk("after_reset_vbuf", vbuf, vbuf_m);

        // Randomized frames of 63, 64 or 65 bits with random wrap delay.
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       n = 63;
                3:       n = 65;
                default: n = 64;
            endcase
            w = {$urandom, $urandom};
            load_word(w);
            if (n == 63) void'(tx_q.pop_back());
            if (n == 65) tx_q.push_back(1'($urandom_range(0, 1)));
            send_bits(tx_q.size());
            end_frame(1'b0);
            tick(6 + $urandom_range(0, 15));
            wrap();
            tick(3);
            chk("rand_vbuf", vbuf, vbuf_m);
            chk("rand_busy", {63'd0, busy}, 64'd0);
        end

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vbuf_loader.md
# vbuf_loader

Serial write port for the LED matrix video buffer: receives a 64-bit frame over a 3-wire SPI-style link (chip select, clock, data) and presents it as the `vbuf` bus that the column scanner reads one byte per column. Frames are assembled in a shadow register and swapped into the display buffer only at a column-scan wrap, so the matrix never shows a half-written frame. It sits between the chip's input pins and the column data mux, clocked by the system clock.

## Interface
- `COLS`, 8, matrix columns (one byte of `vbuf` per column)
- `ROWS`, 8, bits per column
- `SYNC_STAGES`, 2, synchronizer depth for the serial inputs
- `clk` in 1 system clock
- `rst_n` in 1 asynchronous, active-low reset
- `s_cs_n` in 1 frame select, active low, asynchronous to `clk`
- `s_clk` in 1 serial clock, data sampled on its rising edge, asynchronous to `clk`
- `s_data` in 1 serial data, MSB first
- `col_wrap` in 1 one-cycle pulse from the scan counter when column index goes 7 -> 0
- `vbuf` out COLS*ROWS display buffer; `vbuf[8c+7:8c]` is column c
- `busy` out 1 high while a frame is being shifted or is pending swap
- `frame_done` out 1 one-cycle pulse, coincident with the first cycle `vbuf` shows a new frame
- `frame_err` out 1 one-cycle pulse when a frame is discarded

## Operation
- All three serial inputs pass through `SYNC_STAGES` flops, then one edge-detect flop. Only synchronized values are used.
- FSM states: IDLE, SHIFT, PEND.
- IDLE: on synchronized `s_cs_n` falling -> SHIFT; bit counter cleared to 0, shadow unchanged.
- SHIFT: each synchronized `s_clk` rising edge with counter < 64 shifts `shadow <= {shadow[62:0], s_data}` and increments counter (7 bits, saturates at 64). Edges at counter = 64 do not shift and set an internal overflow flag.
- SHIFT, on `s_cs_n` rising: counter == 64 and no overflow -> PEND; otherwise -> IDLE with `frame_err` pulse, shadow content is don't-care.
- PEND: on `col_wrap` high -> `vbuf <= shadow`, `frame_done` pulse, -> IDLE. `s_cs_n` falling while in PEND is ignored for that frame (the whole select window is dropped) and pulses `frame_err` once.
- First bit received lands in `vbuf[63]` (column 7 MSB); last bit in `vbuf[0]`.
- `busy` = (state != IDLE).
- `s_clk` edges while `s_cs_n` is high are ignored.

## Timing
- Reset: `vbuf` = 0, shadow = 0, counter = 0, state IDLE, `busy` = 0, `frame_done` = 0, `frame_err` = 0, sync flops = 1 for `s_cs_n`, 0 for others.
- Reset asserted mid-frame aborts it; no `frame_err`, `vbuf` cleared.
- Pin edge to internal action: 3 `clk` cycles (2 sync + 1 edge detect) for every serial input.
- `s_clk` high and low phases must each be >= 3 `clk` periods; `s_data` stable >= 3 `clk` periods around `s_clk` rise. Faster clocks are unsupported (bits lost, caught as `frame_err`).
- `s_cs_n` rise must follow the last `s_clk` rise by >= 3 `clk` periods.
- Swap latency: `vbuf` and `frame_done` update on the `clk` edge at which `col_wrap` is sampled high in PEND.
- `col_wrap` in the same cycle as the SHIFT -> PEND transition does not swap; next `col_wrap` does.
- `vbuf` is registered and stable between swaps; scanner may read it combinationally.

## Structure
- Shared package `led_pkg`: `COLS`, `ROWS`, `VBUF_W = COLS*ROWS`, FSM state enum, `BITCNT_W = $clog2(VBUF_W)+1`.
- Sub-module `sync_edge` (N-stage synchronizer + rise/fall pulse outputs), instantiated for `s_cs_n`, `s_clk`, `s_data` (data uses level only).
- Top: FSM, bit counter, shadow register, display register.

## Test plan
- Send 64 bits 0xF0E1D2C3B4A59687, raise `s_cs_n`, pulse `col_wrap` 20 cycles later -> `busy` high until swap, `vbuf` = 0xF0E1D2C3B4A59687 and `frame_done` pulse on that edge.
- Send 63 bits then raise `s_cs_n` -> one `frame_err` pulse, state IDLE, `vbuf` unchanged.
- Send 65 bits -> `frame_err` pulse, `vbuf` unchanged.
- Complete frame A, keep `col_wrap` low, start frame B -> `frame_err` once; after `col_wrap`, `vbuf` = A.
- `col_wrap` asserted in same cycle as PEND entry -> no swap; swap at next `col_wrap`.
- Assert `rst_n` low after 30 bits -> `vbuf` = 0, `busy` = 0; a subsequent full frame loads correctly.
